// File: rtl/cc_pkg.sv
// Shared definitions for the punctured K=7 convolutional encoder:
// code rate encoding, generator polynomials (171/133 octal) and puncture tables.
package cc_pkg;

    localparam int K          = 7;
    localparam int STATE_W    = K - 1;
    localparam int PERIOD_MAX = 5;

    localparam logic [K-1:0] GEN_X = 7'o171;
    localparam logic [K-1:0] GEN_Y = 7'o133;

    typedef enum logic [1:0] {
        RATE_1_2 = 2'd0,
        RATE_2_3 = 2'd1,
        RATE_3_4 = 2'd2,
        RATE_5_6 = 2'd3
    } rate_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_TAIL,
        ST_DRAIN
    } fsm_e;

    // Puncture period length per rate, and keep masks indexed by period position
    localparam logic [2:0]            PERIOD_LEN [4] = '{3'd1, 3'd2, 3'd3, 3'd5};
    localparam logic [PERIOD_MAX-1:0] KEEP_X     [4] = '{5'b00001, 5'b00001, 5'b00101, 5'b10101};
    localparam logic [PERIOD_MAX-1:0] KEEP_Y     [4] = '{5'b00001, 5'b00011, 5'b00011, 5'b01011};

    function automatic logic [2:0] period_last(input rate_e r);
        return PERIOD_LEN[r] - 3'd1;
    endfunction

    // Returns {keep_y, keep_x} for the given rate and period position
    function automatic logic [1:0] keep_bits(input rate_e r, input logic [2:0] pos);
        return {KEEP_Y[r][pos], KEEP_X[r][pos]};
    endfunction

endpackage

// File: rtl/cc_mother_core.sv
// Rate-1/2 K=7 mother encoder: 6-bit shift state (bit 0 newest) and X/Y taps.
module cc_mother_core
    import cc_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic shift_en,
    input  logic in_bit,
    output logic x_bit,
    output logic y_bit
);

    logic [STATE_W-1:0] state_q;
    logic [K-1:0]       tap_vec;

    // Arrange input and state so the generator MSB lines up with the newest bit
    always_comb begin
        tap_vec      = '0;
        tap_vec[K-1] = in_bit;
        for (int unsigned i = 0; i < STATE_W; i++) begin
            tap_vec[K-2-i] = state_q[i];
        end
        x_bit = ^(tap_vec & GEN_X);
        y_bit = ^(tap_vec & GEN_Y);
    end

    // Shift register: clears at block start, shifts on every encoded bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= '0;
        end else if (clear) begin
            state_q <= '0;
        end else if (shift_en) begin
            state_q <= {state_q[STATE_W-2:0], in_bit};
        end
    end

endmodule

// File: rtl/cc_punct_enc.sv
// Punctured convolutional encoder (rates 1/2, 2/3, 3/4, 5/6) with a 1-bit
// valid/ready stream on both sides. Define CC_TAIL_FLUSH_EN to append
// TAIL_LEN zero bits after the last data bit of each block.
module cc_punct_enc
    import cc_pkg::*;
#(
    parameter int RATE_W   = 2,
    parameter int TAIL_LEN = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [RATE_W-1:0] rate,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_data,
    output logic              out_last
);

    fsm_e       fsm_q, fsm_nxt;
    rate_e      rate_q, rate_eff;
    logic [2:0] pos_q, pos_nxt;
    logic [1:0] pend_cnt_q, pend_data_q, pend_last_q;
    logic [1:0] new_cnt, new_data, new_last, keep;
    logic       can_load, accept, tail_feed, load, xfer;
    logic       block_end, final_pos, enc_in, x_bit, y_bit;

`ifdef CC_TAIL_FLUSH_EN
    localparam int   TAIL_CW    = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;
    localparam fsm_e AFTER_LAST = ST_TAIL;
    logic [TAIL_CW-1:0] tail_cnt_q;
    logic               tail_done;
`else
    localparam fsm_e AFTER_LAST = ST_DRAIN;
    logic unused_tail_len;
    assign unused_tail_len = (TAIL_LEN != 0);
`endif

    cc_mother_core u_core (
        .clk      (clk),
        .reset    (reset),
        .clear    (block_end),
        .shift_en (load),
        .in_bit   (enc_in),
        .x_bit    (x_bit),
        .y_bit    (y_bit)
    );

    // Handshakes and puncture selection for the bit entering the encoder this cycle
    always_comb begin
        rate_eff  = (fsm_q == ST_IDLE) ? rate_e'(rate[1:0]) : rate_q;
        out_valid = (pend_cnt_q != 2'd0);
        out_data  = pend_data_q[0];
        out_last  = pend_last_q[0];
        xfer      = out_valid & out_ready;
        can_load  = (pend_cnt_q == 2'd0) || ((pend_cnt_q == 2'd1) && out_ready);
        in_ready  = ((fsm_q == ST_IDLE) || (fsm_q == ST_DATA)) && can_load;
        accept    = in_valid & in_ready;
`ifdef CC_TAIL_FLUSH_EN
        tail_feed = (fsm_q == ST_TAIL) && can_load;
        tail_done = tail_feed && (tail_cnt_q == TAIL_CW'(TAIL_LEN - 1));
        final_pos = tail_done;
`else
        tail_feed = 1'b0;
        final_pos = accept & in_last;
`endif
        load      = accept | tail_feed;
        enc_in    = accept & in_data;
        block_end = (fsm_q == ST_DRAIN) && ((xfer && out_last) || (pend_cnt_q == 2'd0));
        pos_nxt   = (pos_q == period_last(rate_eff)) ? 3'd0 : pos_q + 3'd1;
        keep      = keep_bits(rate_eff, pos_q);
        new_cnt   = '0;
        new_data  = '0;
        new_last  = '0;
        case (keep)
            2'b11: begin
                new_cnt  = 2'd2;
                new_data = {y_bit, x_bit};
                new_last = {final_pos, 1'b0};
            end
            2'b01: begin
                new_cnt  = 2'd1;
                new_data = {1'b0, x_bit};
                new_last = {1'b0, final_pos};
            end
            2'b10: begin
                new_cnt  = 2'd1;
                new_data = {1'b0, y_bit};
                new_last = {1'b0, final_pos};
            end
            default: ;
        endcase
    end

    // Block sequencing: idle, data, optional zero tail, drain of pending bits
    always_comb begin
        fsm_nxt = fsm_q;
        case (fsm_q)
            ST_IDLE, ST_DATA: if (accept) fsm_nxt = in_last ? AFTER_LAST : ST_DATA;
            ST_TAIL:          if (final_pos) fsm_nxt = ST_DRAIN;
            ST_DRAIN:         if (block_end) fsm_nxt = ST_IDLE;
            default:          fsm_nxt = ST_IDLE;
        endcase
    end

    // State register and per-block rate latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q  <= ST_IDLE;
            rate_q <= RATE_1_2;
        end else begin
            fsm_q <= fsm_nxt;
            if ((fsm_q == ST_IDLE) && accept) rate_q <= rate_eff;
        end
    end

    // Puncture position counter, restarted at each block boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q <= '0;
        end else if (block_end) begin
            pos_q <= '0;
        end else if (load) begin
            pos_q <= pos_nxt;
        end
    end

    // Pending output bits: a new load replaces a bit leaving in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_cnt_q  <= '0;
            pend_data_q <= '0;
            pend_last_q <= '0;
        end else if (load) begin
            pend_cnt_q  <= new_cnt;
            pend_data_q <= new_data;
            pend_last_q <= new_last;
        end else if (xfer) begin
            pend_cnt_q  <= pend_cnt_q - 2'd1;
            pend_data_q <= {1'b0, pend_data_q[1]};
            pend_last_q <= {1'b0, pend_last_q[1]};
        end
    end

`ifdef CC_TAIL_FLUSH_EN
    // Counts zero bits fed through the encoder after the last data bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tail_cnt_q <= '0;
        end else if (tail_done) begin
            tail_cnt_q <= '0;
        end else if (tail_feed) begin
            tail_cnt_q <= tail_cnt_q + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cc_punct_enc.sv
// Self-checking bench for cc_punct_enc; follows CC_TAIL_FLUSH_EN if defined.
module tb_cc_punct_enc;

    localparam int RATE_W   = 2;
    localparam int TAIL_LEN = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] rate = 2'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_data = 1'b0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_data;
    logic       out_last;

    int n_cmp = 0;
    int n_err = 0;

    bit tx[$];
    bit rx_d[$];
    bit rx_l[$];
    bit exp_d[$];
    bit mdl_u[$];
    int acc_cyc[$];
    int rb_first, rb_last;

    cc_punct_enc #(.RATE_W(RATE_W), .TAIL_LEN(TAIL_LEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .rate      (rate),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // Reference: input history u[n], X taps n,n-1,n-2,n-3,n-6; Y taps n,n-2,n-3,n-5,n-6.
    // Puncturing: X kept at even period positions, Y at position 0 and odd positions.
    function automatic bit u_at(input int k);
        return (k < 0) ? 1'b0 : mdl_u[k];
    endfunction

    function automatic void build_expected(input int rate_v);
        int period;
        int p;
        bit x, y;
        mdl_u = tx;
`ifdef CC_TAIL_FLUSH_EN
        for (int i = 0; i < TAIL_LEN; i++) mdl_u.push_back(1'b0);
`endif
        exp_d.delete();
        case (rate_v)
            0:       period = 1;
            1:       period = 2;
            2:       period = 3;
            default: period = 5;
        endcase
        for (int n = 0; n < mdl_u.size(); n++) begin
            x = u_at(n) ^ u_at(n-1) ^ u_at(n-2) ^ u_at(n-3) ^ u_at(n-6);
            y = u_at(n) ^ u_at(n-2) ^ u_at(n-3) ^ u_at(n-5) ^ u_at(n-6);
            p = n % period;
            if (p % 2 == 0) exp_d.push_back(x);
            if (p == 0 || p % 2 == 1) exp_d.push_back(y);
        end
    endfunction

    function automatic void fill_tx(input int len);
        tx.delete();
        for (int i = 0; i < len; i++) tx.push_back($urandom_range(1) != 0);
    endfunction

    // Drives one block from tx, collects output transfers, checks protocol on the fly.
    // ready_mode: 0 always ready, 1 random, 2 ready low for cycles 4..8.
    task automatic run_block(input int rate_v, input int mid_rate_v, input int ready_mode, input int gap_pct);
        int idx = 0;
        int cyc = 0;
        bit done = 0;
        bit held_v = 0;
        bit held_d = 0;
        bit held_l = 0;
        rx_d.delete();
        rx_l.delete();
        acc_cyc.delete();
        rb_first = -1;
        rb_last  = -1;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            rate = (idx == 0) ? 2'(rate_v) : 2'(mid_rate_v);
            if (idx < tx.size() && $urandom_range(99) >= gap_pct) begin
                in_valid = 1'b1;
                in_data  = tx[idx];
                in_last  = (idx == tx.size() - 1);
            end else begin
                in_valid = 1'b0;
                in_data  = ($urandom_range(1) != 0);
                in_last  = 1'b0;
            end
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(99) < 65);
                default: out_ready = !((cyc >= 4) && (cyc < 9));
            endcase
            #1;
            if (held_v) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== held_d || out_last !== held_l) begin
                    n_err++;
                    $display("FAIL hold_stable cyc %0d got v=%b d=%b l=%b want v=1 d=%b l=%b",
                             cyc, out_valid, out_data, out_last, held_d, held_l);
                end
            end
            if (out_valid && !out_ready) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL stall_in_ready cyc %0d got %b want 0", cyc, in_ready);
                end
            end
            if (idx == tx.size()) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL in_ready_after_last cyc %0d got %b want 0", cyc, in_ready);
                end
            end
            held_v = out_valid && !out_ready;
            held_d = out_data;
            held_l = out_last;
            if (out_valid && out_ready) begin
                rx_d.push_back(out_data);
                rx_l.push_back(out_last);
                if (rb_first < 0) rb_first = cyc;
                rb_last = cyc;
                if (out_last) done = 1;
            end
            if (in_valid && in_ready) begin
                acc_cyc.push_back(cyc);
                idx++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL block_timeout got %0d bits want out_last within 3000 cycles", rx_d.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 1'b0 || out_last !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs got v=%b d=%b l=%b want 0 0 0", out_valid, out_data, out_last);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
    endtask

`ifdef CC_TAIL_FLUSH_EN
    task automatic test_half_tail();
        bit exp14 [14] = '{1,1,1,0,1,1,1,1,0,0,0,1,1,1};
        tx.delete();
        tx.push_back(1'b1);
        run_block(0, 0, 0, 0);
        n_cmp++;
        if (rx_d.size() !== 14) begin
            n_err++;
            $display("FAIL half_tail_len got %0d want 14", rx_d.size());
        end
        for (int i = 0; i < 14 && i < rx_d.size(); i++) begin
            n_cmp++;
            if (rx_d[i] !== exp14[i] || rx_l[i] !== (i == 13)) begin
                n_err++;
                $display("FAIL half_tail_bit %0d got d=%b l=%b want d=%b l=%b", i, rx_d[i], rx_l[i], exp14[i], (i == 13));
            end
        end
    endtask
`else
    task automatic test_three_quarter();
        bit exp4 [4] = '{1,1,0,1};
        tx.delete();
        tx.push_back(1'b1);
        tx.push_back(1'b0);
        tx.push_back(1'b0);
        run_block(2, 2, 0, 0);
        n_cmp++;
        if (rx_d.size() !== 4) begin
            n_err++;
            $display("FAIL r34_len got %0d want 4", rx_d.size());
        end
        for (int i = 0; i < 4 && i < rx_d.size(); i++) begin
            n_cmp++;
            if (rx_d[i] !== exp4[i] || rx_l[i] !== (i == 3)) begin
                n_err++;
                $display("FAIL r34_bit %0d got d=%b l=%b want d=%b l=%b", i, rx_d[i], rx_l[i], exp4[i], (i == 3));
            end
        end
    endtask

    task automatic test_two_thirds();
        bit exp3 [3] = '{1,1,0};
        tx.delete();
        tx.push_back(1'b1);
        tx.push_back(1'b0);
        run_block(1, 1, 0, 0);
        n_cmp++;
        if (rx_d.size() !== 3) begin
            n_err++;
            $display("FAIL r23_len got %0d want 3", rx_d.size());
        end
        for (int i = 0; i < 3 && i < rx_d.size(); i++) begin
            n_cmp++;
            if (rx_d[i] !== exp3[i] || rx_l[i] !== (i == 2)) begin
                n_err++;
                $display("FAIL r23_bit %0d got d=%b l=%b want d=%b l=%b", i, rx_d[i], rx_l[i], exp3[i], (i == 2));
            end
        end
        n_cmp++;
        if (acc_cyc.size() !== 2 || acc_cyc[1] - acc_cyc[0] !== 2) begin
            n_err++;
            $display("FAIL r23_second_accept got gap %0d want 2",
                     (acc_cyc.size() == 2) ? acc_cyc[1] - acc_cyc[0] : -1);
        end
        n_cmp++;
        if (rb_last - rb_first + 1 !== 3) begin
            n_err++;
            $display("FAIL r23_sustained got span %0d want 3", rb_last - rb_first + 1);
        end
    endtask
`endif

    task automatic test_backpressure();
        fill_tx(12);
        run_block(3, 3, 2, 0);
        build_expected(3);
        n_cmp++;
        if (rx_d.size() !== exp_d.size()) begin
            n_err++;
            $display("FAIL bp_len got %0d want %0d", rx_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < rx_d.size(); i++) begin
            n_cmp++;
            if (rx_d[i] !== exp_d[i] || rx_l[i] !== (i == exp_d.size() - 1)) begin
                n_err++;
                $display("FAIL bp_bit %0d got d=%b l=%b want d=%b l=%b", i, rx_d[i], rx_l[i], exp_d[i], (i == exp_d.size() - 1));
            end
        end
    endtask

    task automatic test_rate_change();
        for (int b = 0; b < 2; b++) begin
            int rv;
            rv = (b == 0) ? 0 : 3;
            fill_tx(9 + b);
            run_block(rv, 3, 0, 0);
            build_expected(rv);
            n_cmp++;
            if (rx_d.size() !== exp_d.size()) begin
                n_err++;
                $display("FAIL rchg_len blk %0d got %0d want %0d", b, rx_d.size(), exp_d.size());
            end
            for (int i = 0; i < exp_d.size() && i < rx_d.size(); i++) begin
                n_cmp++;
                if (rx_d[i] !== exp_d[i] || rx_l[i] !== (i == exp_d.size() - 1)) begin
                    n_err++;
                    $display("FAIL rchg_bit blk %0d idx %0d got d=%b l=%b want d=%b l=%b",
                             b, i, rx_d[i], rx_l[i], exp_d[i], (i == exp_d.size() - 1));
                end
            end
            n_cmp++;
            if (rb_last - rb_first + 1 !== rx_d.size()) begin
                n_err++;
                $display("FAIL rchg_sustained blk %0d got span %0d want %0d", b, rb_last - rb_first + 1, rx_d.size());
            end
        end
    endtask

    task automatic test_reset_mid_block();
        int idx = 0;
        int guard = 0;
        fill_tx(4);
        rate = 2'd0;
        out_ready = 1'b1;
        while (idx < tx.size() && guard < 100) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = tx[idx];
            in_last  = (idx == tx.size() - 1);
            #1;
            if (in_ready) idx++;
            guard++;
        end
        n_cmp++;
        if (idx != tx.size()) begin
            n_err++;
            $display("FAIL rst_mid_accept got %0d want %0d", idx, tx.size());
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_pending got %b want 1", out_valid);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_last !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_outputs got v=%b l=%b want 0 0", out_valid, out_last);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_in_ready got %b want 1", in_ready);
        end
        fill_tx(7);
        run_block(1, 2, 1, 20);
        build_expected(1);
        n_cmp++;
        if (rx_d.size() !== exp_d.size()) begin
            n_err++;
            $display("FAIL rst_mid_len got %0d want %0d", rx_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < rx_d.size(); i++) begin
            n_cmp++;
            if (rx_d[i] !== exp_d[i] || rx_l[i] !== (i == exp_d.size() - 1)) begin
                n_err++;
                $display("FAIL rst_mid_bit %0d got d=%b l=%b want d=%b l=%b", i, rx_d[i], rx_l[i], exp_d[i], (i == exp_d.size() - 1));
            end
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < 6; b++) begin
            int rv;
            rv = int'($urandom_range(3));
            fill_tx(int'($urandom_range(16, 1)));
            run_block(rv, int'($urandom_range(3)), 1, 25);
            build_expected(rv);
            n_cmp++;
            if (rx_d.size() !== exp_d.size()) begin
                n_err++;
                $display("FAIL rand_len blk %0d rate %0d got %0d want %0d", b, rv, rx_d.size(), exp_d.size());
            end
            for (int i = 0; i < exp_d.size() && i < rx_d.size(); i++) begin
                n_cmp++;
                if (rx_d[i] !== exp_d[i] || rx_l[i] !== (i == exp_d.size() - 1)) begin
                    n_err++;
                    $display("FAIL rand_bit blk %0d idx %0d got d=%b l=%b want d=%b l=%b",
                             b, i, rx_d[i], rx_l[i], exp_d[i], (i == exp_d.size() - 1));
                end
            end
        end
    endtask

    initial begin
        test_reset();
`ifdef CC_TAIL_FLUSH_EN
        test_half_tail();
`else
        test_three_quarter();
        test_two_thirds();
`endif
        test_backpressure();
        test_rate_change();
        test_reset_mid_block();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
